// File: rtl/vc_credit_tx_if.sv
// Link-side bundle of the credit-based VC transmitter: local per-VC queues in,
// physical link and credit status out.
interface vc_credit_tx_if #(
    parameter int NUM_VC     = 4,
    parameter int FLIT_WIDTH = 128,
    parameter int CREDITS    = 32,
    parameter int VC_W       = $clog2(NUM_VC),
    parameter int CNT_W      = $clog2(CREDITS + 1)
);
    logic [NUM_VC-1:0]            in_valid;
    logic [NUM_VC*FLIT_WIDTH-1:0] in_data;
    logic [NUM_VC-1:0]            in_ready;
    logic                         link_valid;
    logic [VC_W-1:0]              link_vc;
    logic [FLIT_WIDTH-1:0]        link_data;
    logic [NUM_VC-1:0]            credit_in;
    logic [NUM_VC*CNT_W-1:0]      credit_cnt;
    logic                         credit_err;

    // Driver side: VC queues plus downstream credit returns
    modport master (
        output in_valid, in_data, credit_in,
        input  in_ready, link_valid, link_vc, link_data, credit_cnt, credit_err
    );

    // Transmitter side
    modport slave (
        input  in_valid, in_data, credit_in,
        output in_ready, link_valid, link_vc, link_data, credit_cnt, credit_err
    );
endinterface

// File: rtl/vc_credit_tx.sv
// Credit-based transmit end of a router link: per-VC credit counters, round-robin
// VC arbitration, one registered flit per cycle. Define VC_CREDIT_ERR_EN for a sticky overflow flag.
module vc_credit_tx #(
    parameter int NUM_VC     = 4,
    parameter int FLIT_WIDTH = 128,
    parameter int CREDITS    = 32,
    parameter int VC_W       = $clog2(NUM_VC),
    parameter int CNT_W      = $clog2(CREDITS + 1)
) (
    input logic           clk,
    input logic           rst_n,
    vc_credit_tx_if.slave bus_if
);

    localparam logic [CNT_W-1:0] CREDITS_C = CNT_W'(CREDITS);
    localparam logic [VC_W-1:0]  LAST_VC_C = VC_W'(NUM_VC - 1);

    logic [CNT_W-1:0]      cnt_q [NUM_VC];
    logic [CNT_W-1:0]      cnt_d [NUM_VC];
    logic [VC_W-1:0]       rr_q;
    logic [VC_W-1:0]       rr_d;
    logic                  link_valid_q;
    logic                  link_valid_d;
    logic [VC_W-1:0]       link_vc_q;
    logic [VC_W-1:0]       link_vc_d;
    logic [FLIT_WIDTH-1:0] link_data_q;
    logic [FLIT_WIDTH-1:0] link_data_d;

    logic [NUM_VC-1:0]     elig_s;
    logic [NUM_VC-1:0]     grant_s;
    logic [VC_W-1:0]       gnt_idx_s;
    logic                  gnt_any_s;

    // Eligibility: flit waiting and at least one credit left
    always_comb begin
        elig_s = '0;
        for (int i = 0; i < NUM_VC; i++) begin
            elig_s[i] = bus_if.in_valid[i] && (cnt_q[i] != '0);
        end
    end

    // Round-robin arbiter: first pass covers rr..NUM_VC-1, second pass wraps to 0..rr-1
    always_comb begin
        logic found;
        found     = 1'b0;
        grant_s   = '0;
        gnt_idx_s = '0;
        for (int i = 0; i < NUM_VC; i++) begin
            if (!found && elig_s[i] && (VC_W'(i) >= rr_q)) begin
                found      = 1'b1;
                grant_s[i] = 1'b1;
                gnt_idx_s  = VC_W'(i);
            end else begin
                found = found;
            end
        end
        for (int i = 0; i < NUM_VC; i++) begin
            if (!found && elig_s[i] && (VC_W'(i) < rr_q)) begin
                found      = 1'b1;
                grant_s[i] = 1'b1;
                gnt_idx_s  = VC_W'(i);
            end else begin
                found = found;
            end
        end
        // Grants are suppressed while reset is asserted so no queue pops a flit
        if (!rst_n) begin
            grant_s = '0;
        end else begin
            grant_s = grant_s;
        end
    end

    assign gnt_any_s = |grant_s;

    // Pointer advance and link register next-state
    always_comb begin
        rr_d         = rr_q;
        link_valid_d = 1'b0;
        link_vc_d    = link_vc_q;
        link_data_d  = link_data_q;
        if (gnt_any_s) begin
            rr_d        = (gnt_idx_s == LAST_VC_C) ? '0 : (gnt_idx_s + VC_W'(1));
            link_valid_d = 1'b1;
            link_vc_d    = gnt_idx_s;
            link_data_d  = '0;
            for (int i = 0; i < NUM_VC; i++) begin
                if (grant_s[i]) begin
                    link_data_d = link_data_d | bus_if.in_data[i*FLIT_WIDTH +: FLIT_WIDTH];
                end else begin
                    link_data_d = link_data_d;
                end
            end
        end else begin
            rr_d = rr_q;
        end
    end

    // Credit counters: send consumes, pulse returns, saturating at CREDITS
    always_comb begin
        for (int i = 0; i < NUM_VC; i++) begin
            cnt_d[i] = cnt_q[i];
            if (grant_s[i] && !bus_if.credit_in[i]) begin
                cnt_d[i] = cnt_q[i] - CNT_W'(1);
            end else if (bus_if.credit_in[i] && !grant_s[i] && (cnt_q[i] != CREDITS_C)) begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end else begin
                cnt_d[i] = cnt_q[i];
            end
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_VC; i++) begin
                cnt_q[i] <= CREDITS_C;
            end
            rr_q         <= '0;
            link_valid_q <= 1'b0;
            link_vc_q    <= '0;
            link_data_q  <= '0;
        end else begin
            for (int i = 0; i < NUM_VC; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            rr_q         <= rr_d;
            link_valid_q <= link_valid_d;
            link_vc_q    <= link_vc_d;
            link_data_q  <= link_data_d;
        end
    end

`ifdef VC_CREDIT_ERR_EN
    logic [NUM_VC-1:0] ovf_s;
    logic              err_q;
    logic              err_d;

    // Overflow: a credit returned to a VC that already holds every credit
    always_comb begin
        ovf_s = '0;
        for (int i = 0; i < NUM_VC; i++) begin
            ovf_s[i] = (cnt_q[i] == CREDITS_C) && bus_if.credit_in[i] && !grant_s[i];
        end
        err_d = err_q | (|ovf_s);
    end

    // Sticky error flag, cleared only by reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign bus_if.credit_err = err_q;
`else
    assign bus_if.credit_err = 1'b0;
`endif

    assign bus_if.in_ready   = grant_s;
    assign bus_if.link_valid = link_valid_q;
    assign bus_if.link_vc    = link_vc_q;
    assign bus_if.link_data  = link_data_q;

    for (genvar g = 0; g < NUM_VC; g++) begin : g_cnt_out
        assign bus_if.credit_cnt[g*CNT_W +: CNT_W] = cnt_q[g];
    end

endmodule

// File: tb/tb_vc_credit_tx.sv
// Directed bench for vc_credit_tx: a vector table for arbitration and credit
// arithmetic plus hand-written multi-cycle sequences.
module tb_vc_credit_tx;

    localparam int NV = 4;
    localparam int FW = 128;
    localparam int CR = 32;
    localparam int VW = 2;
    localparam int CW = 6;

`ifdef VC_CREDIT_ERR_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;
    int   seq;

    vc_credit_tx_if #(.NUM_VC(NV), .FLIT_WIDTH(FW), .CREDITS(CR), .VC_W(VW), .CNT_W(CW)) bus ();

    vc_credit_tx #(.NUM_VC(NV), .FLIT_WIDTH(FW), .CREDITS(CR), .VC_W(VW), .CNT_W(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus_if(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  valid;
        logic [3:0]  cr;
        logic [3:0]  exp_ready;
        logic        exp_lv;
        logic [1:0]  exp_vc;
        logic [23:0] exp_cnt;   // {vc3, vc2, vc1, vc0}
        logic        exp_err;   // only meaningful with the error flag compiled in
    } vec_t;

    vec_t vecs [11];

    function automatic logic [FW-1:0] pat(input int v, input int s);
        return {32'(s), 32'(v), 32'hC0DE_5A5A, 32'(s) ^ 32'h00FF_00FF};
    endfunction

    task automatic chk(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [NV-1:0] v, input logic [NV-1:0] c);
        seq++;
        bus.in_valid  = v;
        bus.credit_in = c;
        for (int i = 0; i < NV; i++) begin
            bus.in_data[i*FW +: FW] = pat(i, seq);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(4'b0000, 4'b0000);
        tick();
        rst_n = 1'b1;
    endtask

    function automatic logic [CW-1:0] cnt_of(input int v);
        return bus.credit_cnt[v*CW +: CW];
    endfunction

    logic [3:0] gh [64];
    int         nsent;

    initial begin
        errors = 0;
        checks = 0;
        seq    = 0;
        rst_n  = 1'b0;
        drive(4'b0000, 4'b0000);

        vecs[0]  = '{4'b1111, 4'b0000, 4'b0001, 1'b1, 2'd0, {6'd32, 6'd32, 6'd32, 6'd31}, 1'b0};
        vecs[1]  = '{4'b1111, 4'b0000, 4'b0010, 1'b1, 2'd1, {6'd32, 6'd32, 6'd31, 6'd31}, 1'b0};
        vecs[2]  = '{4'b0001, 4'b0000, 4'b0001, 1'b1, 2'd0, {6'd32, 6'd32, 6'd31, 6'd30}, 1'b0};
        vecs[3]  = '{4'b0000, 4'b0001, 4'b0000, 1'b0, 2'd0, {6'd32, 6'd32, 6'd31, 6'd31}, 1'b0};
        vecs[4]  = '{4'b1010, 4'b0010, 4'b0010, 1'b1, 2'd1, {6'd32, 6'd32, 6'd31, 6'd31}, 1'b0};
        vecs[5]  = '{4'b1010, 4'b0000, 4'b1000, 1'b1, 2'd3, {6'd31, 6'd32, 6'd31, 6'd31}, 1'b0};
        vecs[6]  = '{4'b1111, 4'b1000, 4'b0001, 1'b1, 2'd0, {6'd32, 6'd32, 6'd31, 6'd30}, 1'b0};
        vecs[7]  = '{4'b0000, 4'b0100, 4'b0000, 1'b0, 2'd0, {6'd32, 6'd32, 6'd31, 6'd30}, 1'b1};
        vecs[8]  = '{4'b0110, 4'b0000, 4'b0010, 1'b1, 2'd1, {6'd32, 6'd32, 6'd30, 6'd30}, 1'b1};
        vecs[9]  = '{4'b0110, 4'b0000, 4'b0100, 1'b1, 2'd2, {6'd32, 6'd31, 6'd30, 6'd30}, 1'b1};
        vecs[10] = '{4'b0110, 4'b0000, 4'b0010, 1'b1, 2'd1, {6'd32, 6'd31, 6'd29, 6'd30}, 1'b1};

        // Reset state
        tick();
        chk("rst_ready", FW'(bus.in_ready), FW'(0));
        tick();
        chk("rst_lv", FW'(bus.link_valid), FW'(0));
        chk("rst_vc", FW'(bus.link_vc), FW'(0));
        chk("rst_data", bus.link_data, FW'(0));
        chk("rst_cnt", FW'(bus.credit_cnt), FW'({6'd32, 6'd32, 6'd32, 6'd32}));
        chk("rst_err", FW'(bus.credit_err), FW'(0));
        rst_n = 1'b1;

        // Table-driven vectors
        for (int k = 0; k < 11; k++) begin
            int s;
            drive(vecs[k].valid, vecs[k].cr);
            s = seq;
            #1;
            chk($sformatf("v%0d_ready", k), FW'(bus.in_ready), FW'(vecs[k].exp_ready));
            tick();
            chk($sformatf("v%0d_lv", k), FW'(bus.link_valid), FW'(vecs[k].exp_lv));
            chk($sformatf("v%0d_vc", k), FW'(bus.link_vc), FW'(vecs[k].exp_vc));
            chk($sformatf("v%0d_cnt", k), FW'(bus.credit_cnt), FW'(vecs[k].exp_cnt));
            chk($sformatf("v%0d_err", k), FW'(bus.credit_err), FW'(vecs[k].exp_err & ERR_EN));
            if (vecs[k].exp_lv) begin
                chk($sformatf("v%0d_data", k), bus.link_data, pat(int'(vecs[k].exp_vc), s));
            end
        end

        // Single-VC drain: exactly CREDITS flits, then ready drops
        do_reset();
        nsent = 0;
        for (int c = 0; c < 40; c++) begin
            drive(4'b0001, 4'b0000);
            #1;
            chk($sformatf("a%0d_ready", c), FW'(bus.in_ready), (c < CR) ? FW'(1) : FW'(0));
            tick();
            chk($sformatf("a%0d_lv", c), FW'(bus.link_valid), (c < CR) ? FW'(1) : FW'(0));
            if (bus.link_valid) begin
                nsent++;
                chk($sformatf("a%0d_vc", c), FW'(bus.link_vc), FW'(0));
            end
        end
        chk("a_nsent", FW'(nsent), FW'(CR));
        chk("a_cnt", FW'(bus.credit_cnt), FW'({6'd32, 6'd32, 6'd32, 6'd0}));

        // All VCs busy, credits returned three cycles after each send
        do_reset();
        for (int c = 0; c < 40; c++) begin
            int s;
            drive(4'b1111, (c >= 3) ? gh[c-3] : 4'b0000);
            s = seq;
            #1;
            gh[c] = bus.in_ready;
            chk($sformatf("b%0d_ready", c), FW'(bus.in_ready), FW'(4'b0001 << (c % 4)));
            tick();
            chk($sformatf("b%0d_lv", c), FW'(bus.link_valid), FW'(1));
            chk($sformatf("b%0d_vc", c), FW'(bus.link_vc), FW'(c % 4));
            chk($sformatf("b%0d_data", c), bus.link_data, pat(c % 4, s));
            if (c == 20) begin
                chk("b20_cnt", FW'(bus.credit_cnt), FW'({6'd31, 6'd31, 6'd32, 6'd31}));
            end
        end
        for (int c = 40; c < 43; c++) begin
            drive(4'b0000, gh[c-3]);
            tick();
        end
        chk("b_cnt_final", FW'(bus.credit_cnt), FW'({6'd32, 6'd32, 6'd32, 6'd32}));

        // VC2 at zero credits: pulse in N, ready in N+1, on link after N+1
        do_reset();
        for (int c = 0; c < CR; c++) begin
            drive(4'b0100, 4'b0000);
            tick();
        end
        drive(4'b0100, 4'b0000);
        #1;
        chk("c_ready_empty", FW'(bus.in_ready), FW'(0));
        tick();
        chk("c_cnt0", FW'(cnt_of(2)), FW'(0));
        drive(4'b0100, 4'b0100);
        #1;
        chk("c_ready_N", FW'(bus.in_ready), FW'(0));
        tick();
        chk("c_lv_N", FW'(bus.link_valid), FW'(0));
        chk("c_cnt1", FW'(cnt_of(2)), FW'(1));
        drive(4'b0100, 4'b0000);
        #1;
        chk("c_ready_N1", FW'(bus.in_ready), FW'(4'b0100));
        tick();
        chk("c_lv_N2", FW'(bus.link_valid), FW'(1));
        chk("c_vc_N2", FW'(bus.link_vc), FW'(2));
        chk("c_cnt_after", FW'(cnt_of(2)), FW'(0));

        // Grant and credit combinations on VC1 at count 5
        do_reset();
        for (int c = 0; c < 27; c++) begin
            drive(4'b0010, 4'b0000);
            tick();
        end
        chk("d_cnt5", FW'(cnt_of(1)), FW'(5));
        drive(4'b0010, 4'b0010);
        #1;
        chk("d_ready_both", FW'(bus.in_ready), FW'(4'b0010));
        tick();
        chk("d_cnt_both", FW'(cnt_of(1)), FW'(5));
        drive(4'b0010, 4'b0000);
        tick();
        chk("d_cnt_grant", FW'(cnt_of(1)), FW'(4));
        drive(4'b0000, 4'b0010);
        tick();
        chk("d_cnt_credit", FW'(cnt_of(1)), FW'(5));
        chk("d_lv_idle", FW'(bus.link_valid), FW'(0));

        // Overflow on VC3 from full credits
        do_reset();
        chk("e_err_rst", FW'(bus.credit_err), FW'(0));
        drive(4'b0000, 4'b1000);
        tick();
        chk("e_cnt3", FW'(cnt_of(3)), FW'(CR));
        chk("e_err_set", FW'(bus.credit_err), FW'(ERR_EN));
        for (int c = 0; c < 3; c++) begin
            drive(4'b0000, 4'b0000);
            tick();
        end
        chk("e_err_sticky", FW'(bus.credit_err), FW'(ERR_EN));
        do_reset();
        chk("e_err_clr", FW'(bus.credit_err), FW'(0));

        // Reset mid-burst
        do_reset();
        for (int c = 0; c < 5; c++) begin
            drive(4'b1111, 4'b0000);
            tick();
        end
        rst_n = 1'b0;
        drive(4'b1111, 4'b0000);
        #1;
        chk("f_ready_in_rst", FW'(bus.in_ready), FW'(0));
        tick();
        chk("f_lv", FW'(bus.link_valid), FW'(0));
        chk("f_cnt", FW'(bus.credit_cnt), FW'({6'd32, 6'd32, 6'd32, 6'd32}));
        rst_n = 1'b1;
        drive(4'b1111, 4'b0000);
        #1;
        chk("f_ready_first", FW'(bus.in_ready), FW'(4'b0001));
        tick();
        chk("f_lv_first", FW'(bus.link_valid), FW'(1));
        chk("f_vc_first", FW'(bus.link_vc), FW'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vc_credit_tx.md
# vc_credit_tx

Upstream (transmit) end of a credit-based router link. Holds one credit counter per virtual channel, round-robin selects among VCs that have a flit waiting and at least one credit, and drives one flit per cycle onto the physical link with its VC tag. Credits are consumed on send and replenished by one-cycle pulses from the downstream per-VC input FIFOs. One instance sits at each router output port, or at each network-interface injection port.

## Interface
- `NUM_VC`, default 4: number of virtual channels, ≥2.
- `FLIT_WIDTH`, default 128: flit width in bits.
- `CREDITS`, default 32: initial and maximum credits per VC. Equals the downstream per-VC FIFO depth.
- `VC_W`, default `$clog2(NUM_VC)`: VC tag width.
- `CNT_W`, default `$clog2(CREDITS+1)`: credit counter width.
---
- `clk` input 1: clock; all state updates on the rising edge.
- `rst_n` input 1: reset, synchronous, active-low.
- `in_valid` input NUM_VC: per-VC flit available from the local VC queue.
- `in_data` input NUM_VC*FLIT_WIDTH: per-VC flit; VC i occupies bits [i*FLIT_WIDTH +: FLIT_WIDTH].
- `in_ready` output NUM_VC: combinational one-hot grant. The flit on a VC is consumed when `in_valid[i] && in_ready[i]`.
- `link_valid` output 1: registered; flit present on the link this cycle.
- `link_vc` output VC_W: registered VC tag of the link flit.
- `link_data` output FLIT_WIDTH: registered link flit.
- `credit_in` input NUM_VC: per-VC pulse; each cycle high returns exactly one credit.
- `credit_cnt` output NUM_VC*CNT_W: current credit count per VC, registered.
- `credit_err` output 1: sticky credit-overflow flag. Only active when `VC_CREDIT_ERR_EN` is defined.

## Operation
- Eligibility: VC i is eligible when `in_valid[i] && cnt[i] != 0`.
- Arbitration:
  - Round-robin pointer `rr` names the highest-priority VC. Search goes rr, rr+1, … NUM_VC-1, 0, … wrapping.
  - The first eligible VC gets `in_ready` = 1. At most one bit of `in_ready` is set.
  - On a grant to VC g, `rr` becomes (g+1) mod NUM_VC. With no grant, `rr` holds.
- Send: granted flit and tag are registered onto `link_data`/`link_vc`, and `link_valid` is set to 1 for that one cycle. With no grant, `link_valid` = 0 and `link_data`/`link_vc` hold their last values.
- There is no link backpressure. Credits alone guarantee that downstream space exists.
- Credit update per VC each cycle: `cnt_next = cnt - grant[i] + credit_in[i]`, using CNT_W-bit arithmetic.
  - Grant and credit in the same cycle leaves the count unchanged.
  - A grant never occurs when `cnt` = 0, so the count never underflows.
- Overflow: `cnt == CREDITS && credit_in[i] && !grant[i]`. The count saturates at CREDITS.
- VCs are fully independent. A VC with zero credits never blocks other VCs.

## Timing
- Reset values:
  - `cnt[i]` = CREDITS for every VC
  - `rr` = 0
  - `link_valid` = 0, `link_vc` = 0, `link_data` = 0
  - `credit_err` = 0
  - `in_ready` forced to 0 while `rst_n` = 0
- Latency: a flit accepted in cycle N appears on the link in cycle N+1.
- Throughput: one flit per cycle aggregate, given eligible VCs.
- Credit visibility: a credit pulse in cycle N updates `credit_cnt` at N+1, and the VC can be granted in N+1. A VC at 0 credits with a pulse in N can send in N+1.
- Credit round trip and buffer depth: sustained single-VC throughput requires CREDITS ≥ link round-trip cycles.
- Reset mid-operation:
  - In-flight link flit is dropped: `link_valid` = 0 the cycle after reset is sampled.
  - Credits restore to CREDITS.
  - The downstream side must be reset in the same cycle.

## Configuration
- `VC_CREDIT_ERR_EN` defined:
  - Any overflow condition sets `credit_err` on the next edge.
  - It stays 1 until reset.
  - The count still saturates.
- `VC_CREDIT_ERR_EN` undefined: `credit_err` is tied to 0, overflow saturates silently, and no error logic is synthesized.

## Test plan
- Reset, then `in_valid` = 4'b0001 held for 40 cycles with no credit return → exactly 32 link flits, all with `link_vc` = 0. `credit_cnt[0]` reaches 0, `in_ready[0]` drops on cycle 33, and `credit_cnt[1..3]` stay at 32.
- `in_valid` = 4'b1111 continuously, with credits returned one per send, 3 cycles later → `link_vc` sequence is 0,1,2,3,0,1,… with no idle cycles and counts stable near 32.
- VC2 drained to 0 credits, then `in_valid` = 4'b0100 and `credit_in[2]` pulsed in cycle N → `in_ready[2]` = 1 in N+1 and `link_valid` with `link_vc` = 2 in N+2.
- `credit_cnt[1]` = 5 with grant and `credit_in[1]` in the same cycle → count stays 5. Grant alone → 4. Credit alone → 6.
- Reset, then `credit_in[3]` pulsed with no sends → `credit_cnt[3]` stays 32. `credit_err` = 1 next cycle with `VC_CREDIT_ERR_EN`, 0 without it. `credit_err` clears only on reset.
- Traffic on all VCs, `rst_n` low for 1 cycle mid-burst → next cycle `link_valid` = 0, all counts = 32, `rr` = 0. The first grant after reset goes to VC0.
